// File: rtl/branch_predictor_pkg.sv
// ============================================================================
//  branch_predictor_pkg : shared types and counter constants for the BTB
//  Rev 1.0
// ============================================================================
`default_nettype none

package common;

    // Default geometry; the predictor itself derives widths from its parameters
    localparam int unsigned BP_DEF_WIDTH    = 32;
    localparam int unsigned BP_DEF_ENTRIES  = 16;
    localparam int unsigned BP_DEF_CTR_BITS = 2;
    localparam int unsigned BP_DEF_TAG_W    = BP_DEF_WIDTH - $clog2(BP_DEF_ENTRIES) - 2;

    typedef struct packed {
        logic                          valid;
        logic [BP_DEF_TAG_W-1:0]       tag;
        logic [BP_DEF_WIDTH-1:0]       target;
        logic [BP_DEF_CTR_BITS-1:0]    ctr;
    } bp_entry_t;

    // Weakly-taken: MSB set, all lower bits clear
    function automatic int unsigned weak_taken(input int unsigned ctr_bits);
        return 32'd1 << (ctr_bits - 1);
    endfunction

    // Weakly-not-taken: one below weakly-taken
    function automatic int unsigned weak_not_taken(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predictor_sat_counter.sv
// ============================================================================
//  sat_counter : up/down saturating counter with parallel load
//  Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int unsigned          CTR_BITS = 2,
    parameter logic [CTR_BITS-1:0]  RST_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_i,
    input  logic                  dec_i,
    input  logic                  load_i,
    input  logic [CTR_BITS-1:0]   load_val_i,
    output logic [CTR_BITS-1:0]   ctr_o
);

    logic [CTR_BITS-1:0] ctr_q;
    logic [CTR_BITS-1:0] ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (load_i) begin
            ctr_d = load_val_i;
        end else if (inc_i) begin
            if (ctr_q != {CTR_BITS{1'b1}}) ctr_d = ctr_q + 1'b1;
        end else if (dec_i) begin
            if (ctr_q != '0) ctr_d = ctr_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ctr_q <= RST_VAL;
        else     ctr_q <= ctr_d;
    end

    assign ctr_o = ctr_q;

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
//  branch_predictor : direct-mapped BTB with per-entry direction counters
//  Optional statistics outputs under BRANCH_PREDICTOR_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module branch_predictor
    import common::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [WIDTH-1:0]  pred_next_pc,
    input  logic              upd_valid,
    input  logic [WIDTH-1:0]  upd_pc,
    input  logic              upd_taken,
    input  logic [WIDTH-1:0]  upd_target,
`ifdef BRANCH_PREDICTOR_STATS_EN
    output logic [31:0]       stat_updates,
    output logic [31:0]       stat_mispredicts,
`endif
    input  logic              flush
);

    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = WIDTH - IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(weak_taken(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'(weak_not_taken(CTR_BITS));

    typedef struct packed {
        logic                 valid;
        logic [TAG_W-1:0]     tag;
        logic [WIDTH-1:0]     target;
        logic [CTR_BITS-1:0]  ctr;
    } entry_t;

    logic                 valid_q  [ENTRIES];
    logic                 valid_d  [ENTRIES];
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [TAG_W-1:0]     tag_d    [ENTRIES];
    logic [WIDTH-1:0]     target_q [ENTRIES];
    logic [WIDTH-1:0]     target_d [ENTRIES];
    logic [CTR_BITS-1:0]  ctr      [ENTRIES];

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    entry_t           lk_entry;
    logic [IDX-1:0]   up_idx;
    logic [TAG_W-1:0] up_tag;
    entry_t           up_entry;
    logic             up_hit;
    logic             do_upd;

    assign lk_idx   = lookup_pc[IDX+1:2];
    assign lk_tag   = lookup_pc[WIDTH-1:IDX+2];
    assign lk_entry = '{valid: valid_q[lk_idx], tag: tag_q[lk_idx],
                        target: target_q[lk_idx], ctr: ctr[lk_idx]};

    assign pred_hit     = lk_entry.valid && (lk_entry.tag == lk_tag);
    assign pred_taken   = pred_hit && lk_entry.ctr[CTR_BITS-1];
    assign pred_next_pc = pred_taken ? lk_entry.target : lookup_pc + WIDTH'(4);

    assign up_idx   = upd_pc[IDX+1:2];
    assign up_tag   = upd_pc[WIDTH-1:IDX+2];
    assign up_entry = '{valid: valid_q[up_idx], tag: tag_q[up_idx],
                        target: target_q[up_idx], ctr: ctr[up_idx]};
    assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);
    // Flush wins over a coincident update; the update is simply dropped
    assign do_upd   = upd_valid && !flush;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i]  = flush ? 1'b0 : valid_q[i];
            tag_d[i]    = tag_q[i];
            target_d[i] = target_q[i];
        end
        if (do_upd && upd_taken) begin
            valid_d[up_idx]  = 1'b1;
            tag_d[up_idx]    = up_tag;
            target_d[up_idx] = upd_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
            logic sel;
            assign sel = do_upd && (up_idx == IDX'(g));
            sat_counter #(
                .CTR_BITS (CTR_BITS),
                .RST_VAL  (CTR_WEAK_NT)
            ) u_ctr (
                .clk        (clk),
                .rst        (rst),
                .inc_i      (sel && up_hit && upd_taken),
                .dec_i      (sel && up_hit && !upd_taken),
                .load_i     (sel && !up_hit && upd_taken),
                .load_val_i (CTR_WEAK_T),
                .ctr_o      (ctr[g])
            );
        end
    endgenerate

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_upd_q, stat_upd_d;
    logic [31:0] stat_mis_q, stat_mis_d;
    logic        up_pred_t;
    logic        mispred;

    assign up_pred_t = up_hit && up_entry.ctr[CTR_BITS-1];
    assign mispred   = (up_pred_t != upd_taken) ||
                       (up_pred_t && upd_taken && (up_entry.target != upd_target));

    always_comb begin
        stat_upd_d = stat_upd_q;
        stat_mis_d = stat_mis_q;
        if (do_upd) begin
            if (stat_upd_q != 32'hFFFF_FFFF) stat_upd_d = stat_upd_q + 32'd1;
            if (mispred && (stat_mis_q != 32'hFFFF_FFFF)) stat_mis_d = stat_mis_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_upd_q <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_upd_q <= stat_upd_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_updates     = stat_upd_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
//  tb_branch_predictor : directed vector bench for branch_predictor
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        flush;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;
`endif

    int n_cmp;
    int n_bad;

    branch_predictor #(
        .WIDTH    (32),
        .ENTRIES  (16),
        .CTR_BITS (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_pc    (lookup_pc),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_next_pc (pred_next_pc),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
`ifdef BRANCH_PREDICTOR_STATS_EN
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts),
`endif
        .flush        (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        fl;
        logic [31:0] lpc;
        logic        eh;
        logic        et;
        logic [31:0] en;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vec [NVEC];

    task automatic chk(input string nm, input logic h, input logic t, input logic [31:0] n);
        n_cmp++;
        if (pred_hit !== h || pred_taken !== t || pred_next_pc !== n) begin
            n_bad++;
            $display("FAIL %s: got hit=%0b taken=%0b next=%08h, want hit=%0b taken=%0b next=%08h",
                     nm, pred_hit, pred_taken, pred_next_pc, h, t, n);
        end
    endtask

    task automatic idle();
        upd_valid  = 1'b0;
        flush      = 1'b0;
        upd_taken  = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //                uv    upc         ut    utgt        fl    lpc          eh    et    en
        vec[0]  = '{1'b1, 32'h0C, 1'b1, 32'h04,  1'b0, 32'h0C,      1'b1, 1'b1, 32'h04};
        vec[1]  = '{1'b1, 32'h0C, 1'b0, 32'h00,  1'b0, 32'h0C,      1'b1, 1'b0, 32'h10};
        vec[2]  = '{1'b1, 32'h0C, 1'b0, 32'h00,  1'b0, 32'h0C,      1'b1, 1'b0, 32'h10};
        vec[3]  = '{1'b1, 32'h0C, 1'b0, 32'h00,  1'b0, 32'h0C,      1'b1, 1'b0, 32'h10};
        vec[4]  = '{1'b1, 32'h0C, 1'b1, 32'h04,  1'b0, 32'h0C,      1'b1, 1'b0, 32'h10};
        vec[5]  = '{1'b1, 32'h0C, 1'b1, 32'h04,  1'b0, 32'h0C,      1'b1, 1'b1, 32'h04};
        vec[6]  = '{1'b1, 32'h0C, 1'b1, 32'h04,  1'b0, 32'h0C,      1'b1, 1'b1, 32'h04};
        vec[7]  = '{1'b1, 32'h0C, 1'b1, 32'h04,  1'b0, 32'h0C,      1'b1, 1'b1, 32'h04};
        vec[8]  = '{1'b1, 32'h0C, 1'b1, 32'h04,  1'b0, 32'h0C,      1'b1, 1'b1, 32'h04};
        vec[9]  = '{1'b1, 32'h0C, 1'b0, 32'h00,  1'b0, 32'h0C,      1'b1, 1'b1, 32'h04};
        vec[10] = '{1'b1, 32'h0C, 1'b1, 32'h0C,  1'b0, 32'h0C,      1'b1, 1'b1, 32'h0C};
        vec[11] = '{1'b1, 32'h4C, 1'b1, 32'h100, 1'b0, 32'h0C,      1'b0, 1'b0, 32'h10};
        vec[12] = '{1'b0, 32'h00, 1'b0, 32'h00,  1'b0, 32'h4C,      1'b1, 1'b1, 32'h100};
        vec[13] = '{1'b1, 32'h20, 1'b0, 32'h00,  1'b0, 32'h20,      1'b0, 1'b0, 32'h24};
        vec[14] = '{1'b1, 32'h20, 1'b1, 32'h40,  1'b0, 32'h20,      1'b1, 1'b1, 32'h40};
        vec[15] = '{1'b0, 32'h00, 1'b0, 32'h00,  1'b0, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h00};
        vec[16] = '{1'b1, 32'h10, 1'b1, 32'h80,  1'b1, 32'h10,      1'b0, 1'b0, 32'h14};
        vec[17] = '{1'b0, 32'h00, 1'b0, 32'h00,  1'b0, 32'h20,      1'b0, 1'b0, 32'h24};
        vec[18] = '{1'b0, 32'h00, 1'b0, 32'h00,  1'b0, 32'h4C,      1'b0, 1'b0, 32'h50};
        vec[19] = '{1'b1, 32'h0C, 1'b1, 32'h08,  1'b0, 32'h0C,      1'b1, 1'b1, 32'h08};

        idle();
        upd_pc     = '0;
        upd_target = '0;
        lookup_pc  = 32'h0C;
        rst        = 1'b1;
        #2;
        chk("reset", 1'b0, 1'b0, 32'h10);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            upd_valid  = vec[i].uv;
            upd_pc     = vec[i].upc;
            upd_taken  = vec[i].ut;
            upd_target = vec[i].utgt;
            flush      = vec[i].fl;
            lookup_pc  = vec[i].lpc;
            @(posedge clk);
            #1;
            idle();
            chk($sformatf("vec%0d", i), vec[i].eh, vec[i].et, vec[i].en);
        end

        // Same-cycle lookup and update: old value now, new value after the edge
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = 32'h0C;
        upd_taken  = 1'b0;
        lookup_pc  = 32'h0C;
        #1;
        chk("same_cycle_old", 1'b1, 1'b1, 32'h08);
        @(posedge clk);
        #1;
        idle();
        chk("same_cycle_new", 1'b1, 1'b0, 32'h10);

        // Repopulate, then assert reset between edges while an update is pending
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = 32'h0C;
        upd_taken  = 1'b1;
        upd_target = 32'h08;
        @(posedge clk);
        #1;
        chk("pre_reset", 1'b1, 1'b1, 32'h08);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", 1'b0, 1'b0, 32'h10);
        idle();
        @(negedge clk);
        rst = 1'b0;

`ifdef BRANCH_PREDICTOR_STATS_EN
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            upd_valid  = 1'b1;
            upd_pc     = 32'h0C;
            upd_taken  = (i < 4);
            upd_target = 32'h04;
            @(posedge clk);
            #1;
            idle();
        end
        n_cmp++;
        if (stat_updates !== 32'd5) begin
            n_bad++;
            $display("FAIL stat_updates: got %0d want 5", stat_updates);
        end
        n_cmp++;
        if (stat_mispredicts !== 32'd2) begin
            n_bad++;
            $display("FAIL stat_mispredicts: got %0d want 2", stat_mispredicts);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
